// File: rtl/urxd_fsk_frame_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : urxd_fsk_frame_if                                          |
// | Purpose  : Bit-strobe input side and FIFO read side of the FSK UART   |
// |            receiver back end, bundled as one interface.               |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface urxd_fsk_frame_if #(
  parameter int DATA_BITS = 8,
  parameter int AW        = 11,
  parameter int DEPTH     = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // Bit detector side
  logic                 rx_bit;
  logic                 ok_rx_bit;
  logic [AW-1:0]        amp;

  // FIFO read side and status
  logic                 rd_en;
  logic                 clr_ovf;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_ferr;
  logic [AW-1:0]        rd_amp;
  logic                 empty;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 en_rx_byte;
  logic [3:0]           cb_bit;
  logic                 timeout;

  // Driver of bits and reader of words
  modport master (
    output rx_bit, ok_rx_bit, amp, rd_en, clr_ovf,
    input  rd_data, rd_perr, rd_ferr, rd_amp, empty, full, count, overflow,
           en_rx_byte, cb_bit, timeout
  );

  // The receiver itself
  modport slave (
    input  rx_bit, ok_rx_bit, amp, rd_en, clr_ovf,
    output rd_data, rd_perr, rd_ferr, rd_amp, empty, full, count, overflow,
           en_rx_byte, cb_bit, timeout
  );

endinterface
`default_nettype wire

// File: rtl/urxd_fsk_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : urxd_fsk_frame                                             |
// | Purpose  : FSK UART receiver back end. Frames start/data/parity/stop  |
// |            bits from the bit detector strobes, flags parity, stop-bit |
// |            and inter-bit timeout errors, and queues each word with    |
// |            its flags and start-bit amplitude in a show-ahead FIFO.    |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module urxd_fsk_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int AW         = 11,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  urxd_fsk_frame_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int EW = DATA_BITS + 2 + AW;
  localparam logic [3:0] C_LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 w_to_hit;
  logic                 w_strobe;
  logic                 w_push;
  logic                 w_par;
  logic                 w_perr_calc;

  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_cb_bit;
  logic [AW-1:0]        r_amp;
  logic                 r_perr;

  logic [EW-1:0]        r_mem [DEPTH];
  logic [EW-1:0]        w_wr_word;
  logic [EW-1:0]        w_head;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_drop;

  // ---------------------------------------------------------------------
  // Inter-bit timeout. The abort condition is decided from the counter
  // alone, so a strobe landing in the abort clock cannot rescue the frame.
  // ---------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [TW-1:0] r_to_cnt;

      // Count strobe-less clocks while a frame is open; any strobe restarts it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_to_cnt <= '0;
        end else if ((r_state == S_IDLE) || bus.ok_rx_bit) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt != TW'(TIMEOUT)) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end

      assign w_to_hit = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT));
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

  // Running parity over the received data plus the parity bit on the line
  assign w_par       = (^r_shift) ^ bus.rx_bit;
  assign w_perr_calc = (PARITY_ODD != 0) ? ~w_par : w_par;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and push request; only strobes move the FSM, except an abort
  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = bus.ok_rx_bit && !w_to_hit;
    w_push      = 1'b0;
    if (w_to_hit) begin
      w_state_nxt = S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.rx_bit) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_cb_bit == C_LAST_BIT) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_state_nxt = S_STOP;
            end
          end
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          // A low stop bit still ends the frame; it never doubles as a start
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Frame datapath: amplitude latch, LSB-first shift-in, bit count, parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_cb_bit <= '0;
      r_amp    <= '0;
      r_perr   <= 1'b0;
    end else if (w_to_hit) begin
      r_cb_bit <= '0;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.rx_bit) begin
            r_shift  <= '0;
            r_cb_bit <= '0;
            r_amp    <= bus.amp;
            r_perr   <= 1'b0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (r_cb_bit == 4'(i)) begin
              r_shift[i] <= bus.rx_bit;
            end
          end
          r_cb_bit <= r_cb_bit + 4'd1;
        end
        S_PARITY: begin
          r_perr <= w_perr_calc;
        end
        S_STOP: begin
          r_cb_bit <= '0;
        end
        default: begin
          r_cb_bit <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO. Entry = {data, perr, ferr, amp}; ferr is the inverted
  // stop bit taken straight from the line during the stop strobe.
  // ---------------------------------------------------------------------
  assign w_wr_word = {r_shift, r_perr, ~bus.rx_bit, r_amp};
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = bus.rd_en && !w_empty;
  // A pop in the same clock frees the slot, so a full FIFO still accepts
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Storage array; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky overflow; a drop in the same clock as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Head outputs read as zero while empty so they are clean out of reset
  assign w_head         = r_mem[r_rd_ptr];
  assign bus.rd_data    = w_empty ? '0 : w_head[EW-1 -: DATA_BITS];
  assign bus.rd_perr    = !w_empty && w_head[AW+1];
  assign bus.rd_ferr    = !w_empty && w_head[AW];
  assign bus.rd_amp     = w_empty ? '0 : w_head[AW-1:0];
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.en_rx_byte = (r_state != S_IDLE);
  assign bus.cb_bit     = r_cb_bit;
  assign bus.timeout    = w_to_hit;

endmodule
`default_nettype wire

// File: tb/tb_urxd_fsk_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_urxd_fsk_frame                                          |
// | Purpose  : Self-checking bench for urxd_fsk_frame; three parameter    |
// |            sets driven with directed and random frames against a     |
// |            word-level queue model.                                    |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module tb_urxd_fsk_frame;

  // dut0: defaults; dut1: even parity, short timeout; dut2: 9 bits, odd
  // parity, 2-deep FIFO, timeout disabled
  localparam int DB0 = 8,    DB1 = 8,  DB2 = 9;
  localparam int PE0 = 0,    PE1 = 1,  PE2 = 1;
  localparam int PO0 = 0,    PO1 = 0,  PO2 = 1;
  localparam int AW0 = 11,   AW1 = 11, AW2 = 8;
  localparam int DP0 = 4,    DP1 = 4,  DP2 = 2;
  localparam int TO0 = 4096, TO1 = 16, TO2 = 0;

  localparam int DB [3] = '{DB0, DB1, DB2};
  localparam int PE [3] = '{PE0, PE1, PE2};
  localparam int PO [3] = '{PO0, PO1, PO2};
  localparam int AWD[3] = '{AW0, AW1, AW2};
  localparam int DP [3] = '{DP0, DP1, DP2};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-DUT stimulus
  logic        s_rx  [3];
  logic        s_ok  [3];
  logic [10:0] s_amp [3];
  logic        s_rden[3];
  logic        s_clr [3];

  // Per-DUT observed outputs, zero-extended to common widths
  logic [8:0]  o_data [3];
  logic [10:0] o_amp  [3];
  logic [2:0]  o_count[3];
  logic [3:0]  o_cb   [3];
  logic        o_perr [3], o_ferr[3], o_empty[3], o_full[3];
  logic        o_ovf  [3], o_en[3], o_to[3];

  urxd_fsk_frame_if #(.DATA_BITS(DB0), .AW(AW0), .DEPTH(DP0)) if0 ();
  urxd_fsk_frame_if #(.DATA_BITS(DB1), .AW(AW1), .DEPTH(DP1)) if1 ();
  urxd_fsk_frame_if #(.DATA_BITS(DB2), .AW(AW2), .DEPTH(DP2)) if2 ();

  urxd_fsk_frame #(.DATA_BITS(DB0), .PARITY_EN(PE0), .PARITY_ODD(PO0), .AW(AW0),
                   .DEPTH(DP0), .TIMEOUT(TO0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  urxd_fsk_frame #(.DATA_BITS(DB1), .PARITY_EN(PE1), .PARITY_ODD(PO1), .AW(AW1),
                   .DEPTH(DP1), .TIMEOUT(TO1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  urxd_fsk_frame #(.DATA_BITS(DB2), .PARITY_EN(PE2), .PARITY_ODD(PO2), .AW(AW2),
                   .DEPTH(DP2), .TIMEOUT(TO2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.rx_bit = s_rx[0]; assign if0.ok_rx_bit = s_ok[0]; assign if0.amp = s_amp[0][AW0-1:0];
  assign if0.rd_en = s_rden[0]; assign if0.clr_ovf = s_clr[0];
  assign if1.rx_bit = s_rx[1]; assign if1.ok_rx_bit = s_ok[1]; assign if1.amp = s_amp[1][AW1-1:0];
  assign if1.rd_en = s_rden[1]; assign if1.clr_ovf = s_clr[1];
  assign if2.rx_bit = s_rx[2]; assign if2.ok_rx_bit = s_ok[2]; assign if2.amp = s_amp[2][AW2-1:0];
  assign if2.rd_en = s_rden[2]; assign if2.clr_ovf = s_clr[2];

  assign o_data[0] = 9'(if0.rd_data); assign o_amp[0] = 11'(if0.rd_amp); assign o_count[0] = 3'(if0.count);
  assign o_data[1] = 9'(if1.rd_data); assign o_amp[1] = 11'(if1.rd_amp); assign o_count[1] = 3'(if1.count);
  assign o_data[2] = 9'(if2.rd_data); assign o_amp[2] = 11'(if2.rd_amp); assign o_count[2] = 3'(if2.count);
  assign o_cb[0] = if0.cb_bit; assign o_cb[1] = if1.cb_bit; assign o_cb[2] = if2.cb_bit;
  assign o_perr[0] = if0.rd_perr; assign o_perr[1] = if1.rd_perr; assign o_perr[2] = if2.rd_perr;
  assign o_ferr[0] = if0.rd_ferr; assign o_ferr[1] = if1.rd_ferr; assign o_ferr[2] = if2.rd_ferr;
  assign o_empty[0] = if0.empty; assign o_empty[1] = if1.empty; assign o_empty[2] = if2.empty;
  assign o_full[0] = if0.full; assign o_full[1] = if1.full; assign o_full[2] = if2.full;
  assign o_ovf[0] = if0.overflow; assign o_ovf[1] = if1.overflow; assign o_ovf[2] = if2.overflow;
  assign o_en[0] = if0.en_rx_byte; assign o_en[1] = if1.en_rx_byte; assign o_en[2] = if2.en_rx_byte;
  assign o_to[0] = if0.timeout; assign o_to[1] = if1.timeout; assign o_to[2] = if2.timeout;

  // Word-level reference: a bounded queue of received words per DUT
  logic [8:0]  m_data[3][4];
  logic        m_perr[3][4];
  logic        m_ferr[3][4];
  logic [10:0] m_amp [3][4];
  int          m_head[3];
  int          m_cnt [3];
  logic        m_ovf [3];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      m_head[d] = 0;
      m_cnt[d]  = 0;
      m_ovf[d]  = 1'b0;
    end
  endtask

  task automatic m_pop(input int d);
    if (m_cnt[d] > 0) begin
      m_head[d] = (m_head[d] + 1) % DP[d];
      m_cnt[d]--;
    end
  endtask

  task automatic m_push(input int d, input logic [8:0] data, input logic perr,
                        input logic ferr, input logic [10:0] amp, input logic pop_same);
    int slot;
    if (pop_same) m_pop(d);
    if (m_cnt[d] < DP[d]) begin
      slot = (m_head[d] + m_cnt[d]) % DP[d];
      m_data[d][slot] = data;
      m_perr[d][slot] = perr;
      m_ferr[d][slot] = ferr;
      m_amp[d][slot]  = amp;
      m_cnt[d]++;
    end else begin
      m_ovf[d] = 1'b1;
    end
  endtask

  task automatic check_head(input int d, input string tag);
    int h;
    chk({tag, ".empty"}, d, o_empty[d], m_cnt[d] == 0);
    chk({tag, ".full"},  d, o_full[d],  m_cnt[d] == DP[d]);
    chk({tag, ".count"}, d, o_count[d], m_cnt[d]);
    chk({tag, ".ovf"},   d, o_ovf[d],   m_ovf[d]);
    chk({tag, ".busy"},  d, o_en[d],    0);
    if (m_cnt[d] > 0) begin
      h = m_head[d];
      chk({tag, ".data"}, d, o_data[d], m_data[d][h]);
      chk({tag, ".perr"}, d, o_perr[d], m_perr[d][h]);
      chk({tag, ".ferr"}, d, o_ferr[d], m_ferr[d][h]);
      chk({tag, ".amp"},  d, o_amp[d],  m_amp[d][h]);
    end
  endtask

  // One bit strobe after a random idle gap; entered and left on a negedge
  task automatic strobe(input int d, input logic b, input logic [10:0] a, input logic rd);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    s_rx[d] = b; s_amp[d] = a; s_ok[d] = 1'b1; s_rden[d] = rd;
    @(negedge clk);
    s_ok[d] = 1'b0; s_rden[d] = 1'b0;
    s_rx[d] = 1'($urandom); s_amp[d] = 11'($urandom);
  endtask

  // par: 0/1 = raw parity bit, 2 = correct parity; stall_at >= 0 pauses
  // 60 clocks after that data bit (only used where the timeout is off)
  task automatic send_frame(input int d, input logic [8:0] data_in, input int par,
                            input logic stop, input logic pop_same, input int stall_at);
    logic [10:0] a0;
    logic [8:0]  data;
    logic        pb, perr, seen;
    int          ones;
    data = data_in & 9'((1 << DB[d]) - 1);
    a0   = 11'($urandom) & 11'((1 << AWD[d]) - 1);
    ones = $countones(data);
    strobe(d, 1'b0, a0, 1'b0);
    for (int i = 0; i < DB[d]; i++) begin
      strobe(d, data[i], 11'($urandom), 1'b0);
      if (i == stall_at) begin
        chk("stall.cb", d, o_cb[d], i + 1);
        seen = 1'b0;
        repeat (60) begin
          @(negedge clk);
          seen = seen | o_to[d];
        end
        chk("stall.no_timeout", d, seen, 0);
        chk("stall.busy", d, o_en[d], 1);
      end
    end
    perr = 1'b0;
    if (PE[d] != 0) begin
      pb = (par == 2) ? 1'(((ones % 2) != 0) ^ (PO[d] != 0)) : 1'(par);
      perr = (PO[d] != 0) ? (((ones + pb) % 2) != 1) : (((ones + pb) % 2) != 0);
      strobe(d, pb, 11'($urandom), 1'b0);
    end
    strobe(d, stop, 11'($urandom), pop_same);
    if (s_clr[d]) m_ovf[d] = 1'b0;
    m_push(d, data, perr, ~stop, a0, pop_same);
  endtask

  task automatic pop(input int d);
    s_rden[d] = 1'b1;
    @(negedge clk);
    s_rden[d] = 1'b0;
    m_pop(d);
  endtask

  task automatic drain(input int d, input string tag);
    while (m_cnt[d] > 0) begin
      pop(d);
      check_head(d, tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [8:0] w;
    int pulses;
    for (int d = 0; d < 3; d++) begin
      s_rx[d] = 1'b1; s_ok[d] = 1'b0; s_amp[d] = '0; s_rden[d] = 1'b0; s_clr[d] = 1'b0;
    end
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);

    // Reset state
    for (int d = 0; d < 3; d++) begin
      check_head(d, "reset");
      chk("reset.cb", d, o_cb[d], 0);
      chk("reset.timeout", d, o_to[d], 0);
      chk("reset.rd_data", d, o_data[d], 0);
      chk("reset.rd_amp", d, o_amp[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5 on the default configuration
    send_frame(0, 9'h0A5, 2, 1'b1, 1'b0, -1);
    check_head(0, "a5");
    chk("a5.data_const", 0, o_data[0], 9'h0A5);
    drain(0, "a5_pop");

    // Even parity: bad parity, good parity, low stop bit
    send_frame(1, 9'h003, 1, 1'b1, 1'b0, -1);
    check_head(1, "par1");
    chk("par1.perr_const", 1, o_perr[1], 1);
    pop(1); check_head(1, "par1_pop");
    send_frame(1, 9'h003, 0, 1'b1, 1'b0, -1);
    check_head(1, "par0");
    pop(1);
    send_frame(1, 9'h003, 2, 1'b0, 1'b0, -1);
    check_head(1, "ferr");
    chk("ferr.const", 1, o_ferr[1], 1);
    pop(1);
    pop(1);
    check_head(1, "pop_empty");

    // Random frames on every configuration, interleaved with reads
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 8; n++) begin
        send_frame(d, 9'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 3) != 0), 1'b0, -1);
        check_head(d, "rand");
        if ($urandom_range(0, 1) == 1 || m_cnt[d] == DP[d]) begin
          pop(d);
          check_head(d, "rand_pop");
        end
      end
      drain(d, "rand_drain");
    end

    // Overflow: five words into a 4-deep FIFO, then read back and clear
    for (int n = 0; n < 5; n++) send_frame(0, 9'($urandom), 2, 1'b1, 1'b0, -1);
    check_head(0, "ovf_full");
    chk("ovf.flag_const", 0, o_ovf[0], 1);
    for (int n = 0; n < 4; n++) begin
      pop(0);
      check_head(0, "ovf_read");
    end
    s_clr[0] = 1'b1;
    @(negedge clk);
    s_clr[0] = 1'b0;
    m_ovf[0] = 1'b0;
    check_head(0, "ovf_clr");

    // Full FIFO with a read during the fifth stop strobe
    for (int n = 0; n < 4; n++) send_frame(0, 9'($urandom), 2, 1'b1, 1'b0, -1);
    send_frame(0, 9'($urandom), 2, 1'b1, 1'b1, -1);
    check_head(0, "popfull");
    drain(0, "popfull_read");

    // Timeout after start + 3 data bits
    strobe(1, 1'b0, 11'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) strobe(1, 1'($urandom), 11'($urandom), 1'b0);
    chk("to.cb3", 1, o_cb[1], 3);
    chk("to.busy", 1, o_en[1], 1);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (o_to[1]) pulses++;
    end
    chk("to.at16", 1, o_to[1], 1);
    chk("to.pulses_by16", 1, pulses, 1);
    // A start bit during the abort clock must be ignored
    s_rx[1] = 1'b0; s_ok[1] = 1'b1;
    @(negedge clk);
    s_ok[1] = 1'b0; s_rx[1] = 1'b1;
    chk("to.after", 1, o_to[1], 0);
    chk("to.cb0", 1, o_cb[1], 0);
    repeat (20) begin
      @(negedge clk);
      if (o_to[1]) pulses++;
    end
    chk("to.pulses_total", 1, pulses, 1);
    check_head(1, "to_idle");
    send_frame(1, 9'($urandom), 2, 1'b1, 1'b0, -1);
    check_head(1, "to_next");
    drain(1, "to_drain");

    // Disabled timeout: a long stall mid-frame is harmless
    send_frame(2, 9'($urandom), 2, 1'b1, 1'b0, 3);
    check_head(2, "stall");
    drain(2, "stall_drain");

    // Drop and clear in the same clock: the drop wins
    send_frame(2, 9'($urandom), 2, 1'b1, 1'b0, -1);
    send_frame(2, 9'($urandom), 2, 1'b1, 1'b0, -1);
    s_clr[2] = 1'b1;
    send_frame(2, 9'($urandom), 2, 1'b1, 1'b0, -1);
    s_clr[2] = 1'b0;
    check_head(2, "setwins");
    s_clr[2] = 1'b1;
    @(negedge clk);
    s_clr[2] = 1'b0;
    m_ovf[2] = 1'b0;
    check_head(2, "setwins_clr");
    drain(2, "setwins_drain");

    // Asynchronous reset mid-frame with two words stored
    send_frame(0, 9'($urandom), 2, 1'b1, 1'b0, -1);
    send_frame(0, 9'($urandom), 2, 1'b1, 1'b0, -1);
    strobe(0, 1'b0, 11'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) strobe(0, 1'($urandom), 11'($urandom), 1'b0);
    chk("rst.busy_before", 0, o_en[0], 1);
    chk("rst.count_before", 0, o_count[0], 2);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_head(0, "rst_async");
    chk("rst.cb", 0, o_cb[0], 0);
    chk("rst.rd_data", 0, o_data[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = 9'h05A;
    send_frame(0, w, 2, 1'b1, 1'b0, -1);
    check_head(0, "rst_5a");
    chk("rst_5a.data_const", 0, o_data[0], 9'h05A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/urxd_fsk_frame.md
Name: urxd_fsk_frame

Overview:
Parametrised multi-byte FSK UART receiver back end. It sits behind the FSK bit detector and consumes its per-bit decision (rx_bit) and bit strobe (ok_rx_bit). It frames start/data/optional-parity/stop bits and checks parity, stop bit and inter-bit timeout. Each received word goes into a show-ahead FIFO together with error flags and the FSK amplitude latched at the start bit.

Parameters:
DATA_BITS, 8, data bits per word, LSB first, legal 5..9
PARITY_EN, 0, 1 = a parity bit follows the data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
AW, 11, width of the amplitude input and stored amplitude
DEPTH, 4, FIFO entries, power of 2, at least 2
TIMEOUT, 4096, clocks allowed between strobes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_bit  in  1  detected FSK bit, valid while ok_rx_bit=1
ok_rx_bit  in  1  one-clock bit strobe, one per bit interval
amp  in  AW  current FSK harmonic amplitude
rd_en  in  1  pop the FIFO head; ignored when empty
clr_ovf  in  1  clear the sticky overflow flag
rd_data  out  DATA_BITS  FIFO head data
rd_perr  out  1  FIFO head parity error
rd_ferr  out  1  FIFO head frame (stop bit) error
rd_amp  out  AW  FIFO head amplitude, latched at the start bit
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: a word was dropped
en_rx_byte  out  1  high while a frame is in progress (FSM not IDLE)
cb_bit  out  4  data bit counter
timeout  out  1  one-clock pulse when a frame is aborted

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, count=0, empty=1, full=0, overflow=0, timeout=0, en_rx_byte=0, cb_bit=0, shift register=0, rd_* = 0.
- The FSM advances only on clocks with ok_rx_bit=1, except for the timeout abort.
- IDLE:
  - strobe with rx_bit=0 (start bit) -> DATA; cb_bit=0; amp captured; timeout counter cleared.
  - strobe with rx_bit=1 -> stay in IDLE.
- DATA: each strobe shifts rx_bit into data position cb_bit (LSB first) and increments cb_bit. On the DATA_BITS-th strobe -> PARITY if PARITY_EN, else STOP.
- PARITY: on the strobe, compute perr:
  - even mode: perr = (XOR of data ^ rx_bit) != 0
  - odd mode: perr = (XOR of data ^ rx_bit) != 1
  - then -> STOP.
- STOP: on the strobe, ferr = ~rx_bit; push {data, perr, ferr, amp_latched}; -> IDLE. A 0 stop bit is never re-used as a start bit. perr=0 when PARITY_EN=0.
- Timeout: outside IDLE, a counter increments every clock without a strobe and clears on each strobe. When it reaches TIMEOUT:
  - FSM -> IDLE; timeout=1 for one clock; no push; cb_bit=0.
  - A strobe arriving in that same clock is ignored.
- FIFO push latency: the pushed word is visible on rd_* and empty=0 on the clock after the stop strobe (registered pointers, show-ahead head).
- rd_en with empty=0: head advances on that clock edge; new head visible the next cycle. rd_en with empty=1: no effect.
- Push while full with no pop: word dropped, overflow<=1, count unchanged.
- Push and pop in the same clock while full: both accepted, count stays DEPTH, overflow unchanged.
- Push and pop in the same clock while non-full: count unchanged.
- clr_ovf clears overflow. If a drop and clr_ovf coincide, set wins (overflow=1).
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Reset asserted mid-frame: the partial frame is discarded and FIFO contents are lost.

Test Plan:
- Defaults; strobe bits 0, then 1,0,1,0,0,1,0,1 (0xA5 LSB first), then stop 1 -> next clk empty=0, rd_data=0xA5, rd_perr=0, rd_ferr=0, rd_amp=amp value at start strobe, count=1.
- PARITY_EN=1, PARITY_ODD=0; send 0x03 with parity bit 1 -> rd_perr=1. Repeat with parity bit 0 -> rd_perr=0. Send 0x03 with stop bit 0 -> rd_ferr=1, FSM in IDLE.
- DEPTH=4, send 5 words without reading -> full=1, count=4, overflow=1, first 4 words read back in order. clr_ovf -> overflow=0.
- FIFO full, hold rd_en=1 during the 5th stop strobe -> count stays 4, overflow=0, 5th word read last.
- TIMEOUT=16; send start plus 3 data bits, then no strobes -> timeout pulses exactly once 16 clocks after the last strobe, en_rx_byte=0, empty stays 1. The next full frame is received correctly.
- Drop rst_n mid-DATA with 2 words stored -> all outputs at reset values immediately (async), count=0; after release, a new 0x5A frame is received correctly.
